// File: rtl/com_slink_diag_sched_if.sv
// Report handshake bundle for com_slink_diag_sched.
// master: rpt_valid/rpt_data out, rpt_ready in; slave: mirror.
interface com_slink_diag_sched_if #(
  parameter int CHN_NUM = 4
);
  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [2*CHN_NUM-1:0]   rpt_data;

  modport master (
    output rpt_valid,
    output rpt_data,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_data,
    output rpt_ready
  );
endinterface

// File: rtl/com_slink_diag_sched.sv
// Window scheduler for SLINK diag blocks: scans channel errors once
// per window, latches persistent faults, pulses counter clears and
// reports {fault_latch, cur_err} upstream over rpt (valid/ready).
// Ports: clk_12_5m, rst_12_5m (async, active-low), chn_enable,
// chn_slink_err, fault_clr, diag_cnt_clr, fault_latch, slink_fault,
// rpt (report handshake), win_ovr_cnt, scan_busy.
// Optional: define SLINK_DIAG_AUTO_RECOVER_EN for clean-window
// auto-recovery of latched faults (RECOVER_WIN windows).
module com_slink_diag_sched #(
  parameter int          CHN_NUM     = 4,
  parameter logic [15:0] WIN_CYC     = 16'd12500,
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
  parameter logic [3:0]  RECOVER_WIN = 4'd8,
`endif
  parameter logic [3:0]  PERSIST_THR = 4'd3
) (
  input  logic               clk_12_5m,
  input  logic               rst_12_5m,
  input  logic [CHN_NUM-1:0] chn_enable,
  input  logic [CHN_NUM-1:0] chn_slink_err,
  input  logic [CHN_NUM-1:0] fault_clr,
  output logic [CHN_NUM-1:0] diag_cnt_clr,
  output logic [CHN_NUM-1:0] fault_latch,
  output logic               slink_fault,
  com_slink_diag_sched_if.master rpt,
  output logic [7:0]         win_ovr_cnt,
  output logic               scan_busy
);

  localparam int IDX_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CLR,
    RPT
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [15:0]               win_cnt_q, win_cnt_d;
  logic                      win_tick_q, win_tick_d;
  logic [CHN_NUM-1:0][3:0]   pers_q, pers_d;
  logic [CHN_NUM-1:0]        cur_err_q, cur_err_d;
  logic [CHN_NUM-1:0]        fault_q, fault_d;
  logic                      slink_fault_q, slink_fault_d;
  logic [2*CHN_NUM-1:0]      rpt_data_q, rpt_data_d;
  logic [7:0]                ovr_q, ovr_d;
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
  logic [CHN_NUM-1:0][3:0]   clean_q, clean_d;
`endif

  // Free-running window timer; tick is the registered wrap.
  always_comb begin
    win_tick_d = (win_cnt_q == WIN_CYC - 16'd1);
    win_cnt_d  = win_tick_d ? '0 : win_cnt_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rpt_data_d = rpt_data_q;
    unique case (state_q)
      IDLE: begin
        if (win_tick_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(CHN_NUM - 1)) state_d = CLR;
      end
      CLR: begin
        state_d    = RPT;
        rpt_data_d = {fault_q, cur_err_q};
      end
      RPT: begin
        if (rpt.rpt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel scan; a same-cycle set overrides fault_clr.
  always_comb begin
    pers_d    = pers_q;
    cur_err_d = cur_err_q;
    fault_d   = fault_q & ~fault_clr;
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
    clean_d   = clean_q;
`endif
    for (int i = 0; i < CHN_NUM; i++) begin
      if (state_q == SCAN && idx_q == IDX_W'(i)) begin
        if (!chn_enable[i]) begin
          pers_d[i]    = '0;
          cur_err_d[i] = 1'b0;
        end else if (chn_slink_err[i]) begin
          pers_d[i]    = (pers_q[i] == 4'hf) ? 4'hf
                                             : pers_q[i] + 4'd1;
          cur_err_d[i] = 1'b1;
          if (pers_d[i] >= PERSIST_THR) fault_d[i] = 1'b1;
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
          clean_d[i]   = '0;
`endif
        end else begin
          pers_d[i]    = '0;
          cur_err_d[i] = 1'b0;
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
          clean_d[i]   = (clean_q[i] == 4'hf) ? 4'hf
                                              : clean_q[i] + 4'd1;
          if (clean_d[i] >= RECOVER_WIN && fault_q[i])
            fault_d[i] = 1'b0;
`endif
        end
      end
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (win_tick_q && state_q != IDLE && ovr_q != 8'hff)
      ovr_d = ovr_q + 8'd1;
    slink_fault_d = |(fault_q & chn_enable);
  end

  always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
    if (!rst_12_5m) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      win_cnt_q     <= '0;
      win_tick_q    <= 1'b0;
      pers_q        <= '0;
      cur_err_q     <= '0;
      fault_q       <= '0;
      slink_fault_q <= 1'b0;
      rpt_data_q    <= '0;
      ovr_q         <= '0;
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
      clean_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      win_cnt_q     <= win_cnt_d;
      win_tick_q    <= win_tick_d;
      pers_q        <= pers_d;
      cur_err_q     <= cur_err_d;
      fault_q       <= fault_d;
      slink_fault_q <= slink_fault_d;
      rpt_data_q    <= rpt_data_d;
      ovr_q         <= ovr_d;
`ifdef SLINK_DIAG_AUTO_RECOVER_EN
      clean_q       <= clean_d;
`endif
    end
  end

  assign diag_cnt_clr  = (state_q == CLR) ? chn_enable : '0;
  assign fault_latch   = fault_q;
  assign slink_fault   = slink_fault_q;
  assign rpt.rpt_valid = (state_q == RPT);
  assign rpt.rpt_data  = rpt_data_q;
  assign win_ovr_cnt   = ovr_q;
  assign scan_busy     = (state_q != IDLE);

endmodule

// File: doc/com_slink_diag_sched.md
Name: com_slink_diag_sched

Overview:
Window-based scheduler for the per-channel SLINK diagnostic blocks on the MC board. It runs a fixed observation window and scans each channel's diag error output once per window. It tracks how many consecutive windows each channel has been in error and latches a persistent fault. It then pulses a counter-clear to the diag blocks so their error counters restart each window, and hands a status report upstream over a valid/ready handshake.

Parameters:
CHN_NUM, 4, number of SLINK channels scheduled (1..16)
WIN_CYC, 16'd12500, observation window length in clk_12_5m cycles (1 ms); min CHN_NUM+3
PERSIST_THR, 4'd3, consecutive erroneous windows before fault latches (1..15)
RECOVER_WIN, 4'd8, consecutive clean windows for auto-recovery (optional feature only)

Ports:
clk_12_5m  input  1  sole clock, 12.5 MHz
rst_12_5m  input  1  asynchronous reset, active-low
chn_enable  input  CHN_NUM  per-channel enable
chn_slink_err  input  CHN_NUM  per-channel error level from each diag block
fault_clr  input  CHN_NUM  per-channel single-cycle fault latch clear
diag_cnt_clr  output  CHN_NUM  one-cycle clear pulse to diag error counters
fault_latch  output  CHN_NUM  sticky persistent-fault flags
slink_fault  output  1  OR of fault_latch over enabled channels
rpt_valid  output  1  report valid
rpt_ready  input  1  report accept
rpt_data  output  2*CHN_NUM  {fault_latch, cur_err}
win_ovr_cnt  output  8  count of dropped window ticks, saturating
scan_busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, win_cnt 0, persist counters 0. Async assert; rpt_valid drops immediately, even mid-report.
- Window timer: win_cnt increments every cycle. At WIN_CYC-1 it wraps to 0, and registered win_tick is high for the following cycle. The timer is free-running, independent of the FSM.
- FSM states: IDLE, SCAN, CLR, RPT.
- IDLE -> SCAN on win_tick; chn_idx <= 0.
- SCAN: one channel per cycle, idx 0..CHN_NUM-1, then -> CLR. For channel i:
  - chn_enable[i]=0: persist[i] <= 0, cur_err[i] <= 0, fault_latch unchanged.
  - else if chn_slink_err[i]=1: persist[i] saturating +1 (4-bit, max 15), cur_err[i] <= 1; if new persist >= PERSIST_THR, fault_latch[i] <= 1.
  - else: persist[i] <= 0, cur_err[i] <= 0.
- CLR: diag_cnt_clr = chn_enable for exactly one cycle -> RPT.
- RPT: rpt_valid=1. rpt_data is captured on RPT entry and held stable until transfer.
  - Transfer occurs on rpt_valid & rpt_ready; next cycle rpt_valid=0 and FSM -> IDLE.
  - rpt_ready is ignored outside RPT.
- Latency: win_tick at cycle T -> SCAN T+1..T+CHN_NUM -> CLR at T+CHN_NUM+1 -> rpt_valid at T+CHN_NUM+2 at the earliest.
- Overrun: win_tick while FSM != IDLE is dropped; win_ovr_cnt +1, saturating at 255. No queued scan.
- fault_clr[i] clears fault_latch[i] next cycle. If a set and a clear of the same bit occur in the same cycle, set wins. Does not reset persist[i].
- slink_fault = |(fault_latch & chn_enable), registered one cycle after fault_latch.
- Channel disabled while latched: fault_latch kept; slink_fault masks it.
- chn_slink_err is sampled only during that channel's SCAN cycle; pulses at other times are not seen.

Optional Feature:
SLINK_DIAG_AUTO_RECOVER_EN
- Defined: per-channel 4-bit clean-window counter, incremented saturating on each clean enabled scan and zeroed on an error scan. When it reaches RECOVER_WIN with fault_latch[i]=1, fault_latch[i] clears in that SCAN cycle.
- Undefined: fault_latch clears only via fault_clr or reset; no clean counters are synthesized.

Test Plan:
(All with CHN_NUM=4, WIN_CYC=100, PERSIST_THR=3, rpt_ready tied 1 unless stated.)
- Error persistence: ch1 err held 1 for 3 windows -> persist1 reaches 3 on the third scan, fault_latch=4'b0010, slink_fault=1, rpt_data=8'b0010_0010 on window 3.
- Non-consecutive errors: ch2 err in windows 1 and 2, clean in window 3, err in window 4 -> fault_latch[2] stays 0; persist resets to 0 in window 3.
- Handshake: rpt_ready=0 for 150 cycles across a tick -> rpt_valid and rpt_data held stable, win_ovr_cnt=1; on rpt_ready=1 one transfer, then IDLE.
- Clear pulse and disable: chn_enable=4'b1011 -> diag_cnt_clr=4'b1011 for exactly 1 cycle per window, at tick+5; ch2 err ignored.
- Clear vs set: fault_clr[1] in the same cycle that SCAN sets ch1 -> fault_latch[1]=1. A later fault_clr clears it with persist unchanged.
- Async reset mid-RPT: rpt_valid=0 immediately, all flags 0. With the feature macro defined, 8 clean windows after a ch0 fault -> fault_latch[0]=0.
